// File: rtl/load_mask_unit.sv
// load_mask_unit: single-outstanding memory load with size masking and
// sign/zero extension. A load is requested in IDLE, the read strobe is held
// for MEM_LAT cycles, the read data is captured on the last of them and the
// extended result is announced by a one-cycle DONE pulse.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   START     - load request, sampled only in IDLE
//   ADDR      - byte address of the load (latched at the START edge)
//   CT        - size code: 00 word, 01 halfword, 10 byte, 11 word
//   SGN       - 1 sign-extends halfword/byte results, 0 zero-extends
//   MR        - memory read data, valid on the last WAIT cycle
//   MEM_RD    - memory read strobe, high in every WAIT cycle
//   MEM_ADDR  - address presented to memory, held outside WAIT
//   OUT       - extracted, extended load result, held between captures
//   BUSY      - high in WAIT and DONE
//   DONE      - one-cycle pulse, OUT valid from this cycle onward
module load_mask_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        START,
  input  logic [31:0] ADDR,
  input  logic [1:0]  CT,
  input  logic        SGN,
  input  logic [31:0] MR,
  output logic        MEM_RD,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] OUT,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CT_W   = 2;

  // Counter preload: the WAIT state lasts (preload + 1) cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CT_W-1:0]     ct_q, ct_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   addr_d;
  logic [DATA_W-1:0]   out_d;
  logic                rd_d;
  logic                busy_d;
  logic                done_d;
  logic [DATA_W-1:0]   ext_c;

  // Size masking and extension of the read data; lane is always the low bytes.
  always_comb begin
    ext_c = MR;
    case (ct_q)
      2'b01:   ext_c = {{16{sgn_q & MR[15]}}, MR[15:0]};
      2'b10:   ext_c = {{24{sgn_q & MR[7]}},  MR[7:0]};
      default: ext_c = MR;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    sgn_d   = sgn_q;
    addr_d  = MEM_ADDR;
    out_d   = OUT;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d  = ADDR;
          ct_d    = CT;
          sgn_d   = SGN;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d   = ext_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    rd_d   = (state_d == ST_WAIT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ct_q     <= '0;
      sgn_q    <= 1'b0;
      MEM_ADDR <= '0;
      OUT      <= '0;
      MEM_RD   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ct_q     <= ct_d;
      sgn_q    <= sgn_d;
      MEM_ADDR <= addr_d;
      OUT      <= out_d;
      MEM_RD   <= rd_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
    end
  end

endmodule

// File: doc/load_mask_unit.md
LOAD_MASK_UNIT -- requirements
Module: load_mask_unit

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  load request; sampled only in IDLE.
REQ-005 SHALL have port ADDR  input  32  byte address of the load.
REQ-006 SHALL have port CT  input  2  size code: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-007 SHALL have port SGN  input  1  1 = sign-extend halfword/byte results, 0 = zero-extend.
REQ-008 SHALL have port MR  input  32  memory read data, valid on the last WAIT cycle.
REQ-009 SHALL have port MEM_RD  output  1  memory read strobe.
REQ-010 SHALL have port MEM_ADDR  output  32  address presented to memory.
REQ-011 SHALL have port OUT  output  32  extracted, extended load result.
REQ-012 SHALL have port BUSY  output  1  high in WAIT and DONE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse; OUT is valid from this cycle onward.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE, with a 4-bit wait counter.
REQ-015 SHALL, in IDLE with START=1 at an edge, latch ADDR, CT and SGN, load the counter with MEM_LAT-1, and enter WAIT.
REQ-016 SHALL, in IDLE with START=0, remain in IDLE.
REQ-017 SHALL drive MEM_RD=1 and MEM_ADDR=latched ADDR in every WAIT cycle, and MEM_RD=0 otherwise.
REQ-018 SHALL hold MEM_ADDR at its last value outside WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each edge while it is nonzero.
REQ-020 SHALL, at the WAIT edge where the counter is 0, capture MR, update OUT and enter DONE.
REQ-021 SHALL, for word (CT=00 or 11), set OUT=MR.
REQ-022 SHALL, for halfword (CT=01), set OUT[15:0]=MR[15:0] and fill OUT[31:16] with MR[15] if SGN=1, else 0.
REQ-023 SHALL, for byte (CT=10), set OUT[7:0]=MR[7:0] and fill OUT[31:8] with MR[7] if SGN=1, else 0.
REQ-024 SHALL use only MR's low bytes; ADDR[1:0] is not used for lane selection.
REQ-025 SHALL assert DONE=1 for exactly the single cycle spent in DONE, then return to IDLE.
REQ-026 SHALL give a latency of MEM_LAT+1 cycles from the START-sampling edge to DONE high.
REQ-027 SHALL accept back-to-back loads no more often than one per MEM_LAT+2 cycles.
REQ-028 SHALL ignore START in WAIT and DONE, with no queuing.
REQ-029 SHALL not sample changes to ADDR, CT or SGN after the START edge.
REQ-030 SHALL hold OUT between captures; OUT changes only at the capture edge or at reset.
REQ-031 SHALL, when MEM_LAT=1, spend exactly one cycle in WAIT.

Reset
REQ-032 SHALL, on reset=1, immediately and without a clock force state IDLE, counter=0, MEM_RD=0, MEM_ADDR=0, OUT=0, BUSY=0, DONE=0.
REQ-033 SHALL, on reset during WAIT or DONE, abort the load with no DONE pulse and leave OUT=0.
REQ-034 SHALL accept START on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL be verified with a word load: MEM_LAT=1, MR=0x12345678, CT=00, START pulse -> MEM_RD high 1 cycle, DONE 2 cycles after the START edge, OUT=0x12345678.
REQ-036 SHALL be verified with size sweeps: MR=0xFFFFFFFF, SGN=0, CT=01 -> OUT=0x0000FFFF; CT=10 -> OUT=0x000000FF; CT=11 -> OUT=0xFFFFFFFF.
REQ-037 SHALL be verified with sign extension: MR=0x000080F0, SGN=1, CT=10 -> 0xFFFFFFF0; CT=01 -> 0xFFFF80F0; SGN=0, CT=10 -> 0x000000F0.
REQ-038 SHALL be verified with latency: MEM_LAT=3, START held high continuously -> MEM_RD high 3 cycles, DONE every 5th cycle, no extra loads.
REQ-039 SHALL be verified with reset mid-load: reset asserted in the 2nd WAIT cycle with MEM_LAT=3 -> outputs zero at once, no DONE, next START completes normally.
REQ-040 SHALL be verified with input change: ADDR/CT altered in WAIT -> MEM_ADDR and the result use the latched values.
